// File: rtl/ccss_mem_pkg.sv
// Shared definitions for the dual-core data memory controllers.
package ccss_mem_pkg;

  localparam int unsigned CORE_AR_W = 16;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;

  typedef enum logic [0:0] {
    BUF_EMPTY   = 1'b0,
    BUF_PENDING = 1'b1
  } buf_state_e;

  typedef enum logic [0:0] {
    CORE1 = 1'b0,
    CORE2 = 1'b1
  } core_idx_e;

  function automatic core_idx_e other_core(input core_idx_e c);
    return (c == CORE1) ? CORE2 : CORE1;
  endfunction

endpackage

// File: rtl/mem_wr_buffer.sv
// One-entry store buffer: captures a request when empty, holds it until granted.
module mem_wr_buffer #(
  parameter int unsigned ADDR_W = ccss_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = ccss_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              grant,
  output logic              pending,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  import ccss_mem_pkg::*;

  buf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // A pending entry ignores new requests, including on its grant edge.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      BUF_EMPTY: begin
        if (wr_req) begin
          state_d = BUF_PENDING;
          addr_d  = wr_addr;
          data_d  = wr_data;
        end
      end
      BUF_PENDING: begin
        if (grant) state_d = BUF_EMPTY;
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  assign pending = (state_q == BUF_PENDING);
  assign addr    = addr_q;
  assign data    = data_q;

endmodule

// File: rtl/mem_write_arbiter.sv
// Arbitrates buffered stores from two cores onto the shared data memory write port.
// Optional feature: MEMW_COLLISION_MERGE_EN merges same-address stores into one write.
module mem_write_arbiter #(
  parameter int unsigned CORE_AR_W = ccss_mem_pkg::CORE_AR_W,
  parameter int unsigned ADDR_W    = ccss_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W    = ccss_mem_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 c1_wr_req,
  input  logic [CORE_AR_W-1:0] c1_AR,
  input  logic [DATA_W-1:0]    c1_DR,
  output logic                 c1_busy,
  output logic                 c1_wr_ack,
  input  logic                 c2_wr_req,
  input  logic [CORE_AR_W-1:0] c2_AR,
  input  logic [DATA_W-1:0]    c2_DR,
  output logic                 c2_busy,
  output logic                 c2_wr_ack,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [DATA_W-1:0]    mem_data,
  output logic                 mem_wren,
  output logic                 collision
);
  import ccss_mem_pkg::*;

  logic              pend1, pend2;
  logic [ADDR_W-1:0] addr1, addr2;
  logic [DATA_W-1:0] data1, data2;
  logic              grant1, grant2, coll;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  core_idx_e         rr_q, rr_d;

  logic unused_ar_hi;
  assign unused_ar_hi = ^{c1_AR[CORE_AR_W-1:ADDR_W], c2_AR[CORE_AR_W-1:ADDR_W]};

  mem_wr_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf1 (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (c1_wr_req),
    .wr_addr (c1_AR[ADDR_W-1:0]),
    .wr_data (c1_DR),
    .grant   (grant1),
    .pending (pend1),
    .addr    (addr1),
    .data    (data1)
  );

  mem_wr_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf2 (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (c2_wr_req),
    .wr_addr (c2_AR[ADDR_W-1:0]),
    .wr_data (c2_DR),
    .grant   (grant2),
    .pending (pend2),
    .addr    (addr2),
    .data    (data2)
  );

  assign c1_busy = pend1;
  assign c2_busy = pend2;

  // Grant selection; when both cores win (merge), core 2's data is written.
  always_comb begin
    grant1   = 1'b0;
    grant2   = 1'b0;
    coll     = 1'b0;
    rr_d     = rr_q;
    if (pend1 && pend2) begin
      coll = (addr1 == addr2);
`ifdef MEMW_COLLISION_MERGE_EN
      if (coll) begin
        grant1 = 1'b1;
        grant2 = 1'b1;
      end else begin
        grant1 = (rr_q == CORE1);
        grant2 = (rr_q == CORE2);
        rr_d   = other_core(rr_q);
      end
`else
      grant1 = (rr_q == CORE1);
      grant2 = (rr_q == CORE2);
      rr_d   = other_core(rr_q);
`endif
    end else begin
      grant1 = pend1;
      grant2 = pend2;
    end
    sel_addr = grant2 ? addr2 : addr1;
    sel_data = grant2 ? data2 : data1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      c1_wr_ack   <= 1'b0;
      c2_wr_ack   <= 1'b0;
      collision   <= 1'b0;
      rr_q        <= CORE1;
    end else begin
      mem_wren  <= grant1 | grant2;
      c1_wr_ack <= grant1;
      c2_wr_ack <= grant2;
      collision <= coll;
      rr_q      <= rr_d;
      if (grant1 | grant2) begin
        mem_address <= sel_addr;
        mem_data    <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Directed self-checking bench for mem_write_arbiter (honours MEMW_COLLISION_MERGE_EN).
module tb_mem_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c1_wr_req, c2_wr_req;
  logic [15:0] c1_AR, c2_AR, c1_DR, c2_DR;
  logic        c1_busy, c2_busy, c1_wr_ack, c2_wr_ack;
  logic [7:0]  mem_address;
  logic [15:0] mem_data;
  logic        mem_wren, collision;

  int vectors    = 0;
  int miscompares = 0;
  int ack_count  = 0;
  logic exp_rr_c2;

  always #5 clk = ~clk;

  mem_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .c1_wr_req   (c1_wr_req),
    .c1_AR       (c1_AR),
    .c1_DR       (c1_DR),
    .c1_busy     (c1_busy),
    .c1_wr_ack   (c1_wr_ack),
    .c2_wr_req   (c2_wr_req),
    .c2_AR       (c2_AR),
    .c2_DR       (c2_DR),
    .c2_busy     (c2_busy),
    .c2_wr_ack   (c2_wr_ack),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .collision   (collision)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic wren, input logic a1, input logic a2,
                       input logic coll, input logic b1, input logic b2);
    chk({tag, "/wren"}, 32'(mem_wren), 32'(wren));
    chk({tag, "/ack1"}, 32'(c1_wr_ack), 32'(a1));
    chk({tag, "/ack2"}, 32'(c2_wr_ack), 32'(a2));
    chk({tag, "/coll"}, 32'(collision), 32'(coll));
    chk({tag, "/busy1"}, 32'(c1_busy), 32'(b1));
    chk({tag, "/busy2"}, 32'(c2_busy), 32'(b2));
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [15:0] d);
    chk({tag, "/addr"}, 32'(mem_address), 32'(a));
    chk({tag, "/data"}, 32'(mem_data), 32'(d));
  endtask

  initial begin
    rst = 1'b1;
    c1_wr_req = 1'b0; c2_wr_req = 1'b0;
    c1_AR = '0; c2_AR = '0; c1_DR = '0; c2_DR = '0;

    // Reset and idle
    repeat (2) tick();
    flags("reset", 0, 0, 0, 0, 0, 0);
    wr("reset", 8'h00, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      flags("idle", 0, 0, 0, 0, 0, 0);
    end
    wr("idle", 8'h00, 16'h0000);

    // Single uncontended c1 store
    c1_wr_req = 1'b1; c1_AR = 16'h0012; c1_DR = 16'hABCD;
    tick();
    c1_wr_req = 1'b0;
    flags("single_cap", 0, 0, 0, 0, 1, 0);
    tick();
    flags("single_wr", 1, 1, 0, 0, 0, 0);
    wr("single_wr", 8'h12, 16'hABCD);
    tick();
    flags("single_after", 0, 0, 0, 0, 0, 0);
    wr("single_hold", 8'h12, 16'hABCD);

    // Contention, distinct addresses, rr at core 1
    c1_wr_req = 1'b1; c1_AR = 16'h0005; c1_DR = 16'h1111;
    c2_wr_req = 1'b1; c2_AR = 16'h0006; c2_DR = 16'h2222;
    tick();
    c1_wr_req = 1'b0; c2_wr_req = 1'b0;
    flags("cont_cap", 0, 0, 0, 0, 1, 1);
    tick();
    flags("cont_first", 1, 1, 0, 0, 0, 1);
    wr("cont_first", 8'h05, 16'h1111);
    tick();
    flags("cont_second", 1, 0, 1, 0, 0, 0);
    wr("cont_second", 8'h06, 16'h2222);
    tick();
    flags("cont_after", 0, 0, 0, 0, 0, 0);

    // Same-address collision, rr now at core 2
    c1_wr_req = 1'b1; c1_AR = 16'h0020; c1_DR = 16'hAAAA;
    c2_wr_req = 1'b1; c2_AR = 16'h0020; c2_DR = 16'hBBBB;
    tick();
    c1_wr_req = 1'b0; c2_wr_req = 1'b0;
    flags("coll_cap", 0, 0, 0, 0, 1, 1);
    tick();
`ifdef MEMW_COLLISION_MERGE_EN
    flags("coll_merge", 1, 1, 1, 1, 0, 0);
    wr("coll_merge", 8'h20, 16'hBBBB);
    tick();
    flags("coll_after", 0, 0, 0, 0, 0, 0);
    exp_rr_c2 = 1'b1;
`else
    flags("coll_first", 1, 0, 1, 1, 1, 0);
    wr("coll_first", 8'h20, 16'hBBBB);
    tick();
    flags("coll_second", 1, 1, 0, 0, 0, 0);
    wr("coll_second", 8'h20, 16'hAAAA);
    tick();
    flags("coll_after", 0, 0, 0, 0, 0, 0);
    exp_rr_c2 = 1'b0;
`endif

    // Further contention follows the expected rr pointer
    c1_wr_req = 1'b1; c1_AR = 16'h0030; c1_DR = 16'h3333;
    c2_wr_req = 1'b1; c2_AR = 16'h0031; c2_DR = 16'h4444;
    tick();
    c1_wr_req = 1'b0; c2_wr_req = 1'b0;
    tick();
    if (exp_rr_c2) begin
      flags("rr_first", 1, 0, 1, 0, 1, 0);
      wr("rr_first", 8'h31, 16'h4444);
    end else begin
      flags("rr_first", 1, 1, 0, 0, 0, 1);
      wr("rr_first", 8'h30, 16'h3333);
    end
    tick();
    if (exp_rr_c2) begin
      flags("rr_second", 1, 1, 0, 0, 0, 0);
      wr("rr_second", 8'h30, 16'h3333);
    end else begin
      flags("rr_second", 1, 0, 1, 0, 0, 0);
      wr("rr_second", 8'h31, 16'h4444);
    end
    tick();
    flags("rr_after", 0, 0, 0, 0, 0, 0);

    // c1 holds its request: one ack every 2 cycles
    c1_wr_req = 1'b1; c1_AR = 16'h0040; c1_DR = 16'h5000;
    ack_count = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (c1_wr_ack) ack_count++;
      chk("hold_ack", 32'(c1_wr_ack), 32'(i % 2));
      chk("hold_busy", 32'(c1_busy), 32'((i + 1) % 2));
    end
    c1_wr_req = 1'b0;
    tick();
    flags("hold_after", 0, 0, 0, 0, 0, 0);
    chk("hold_count", 32'(ack_count), 32'd3);

    // Reset while both buffers pending discards both stores
    c1_wr_req = 1'b1; c1_AR = 16'h0070; c1_DR = 16'h7777;
    c2_wr_req = 1'b1; c2_AR = 16'h0071; c2_DR = 16'h8888;
    tick();
    c1_wr_req = 1'b0; c2_wr_req = 1'b0;
    flags("rst_cap", 0, 0, 0, 0, 1, 1);
    rst = 1'b1;
    #1;
    flags("rst_async", 0, 0, 0, 0, 0, 0);
    wr("rst_async", 8'h00, 16'h0000);
    tick();
    flags("rst_hold", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      flags("rst_release", 0, 0, 0, 0, 0, 0);
    end

    // New c2 store after reset completes normally
    c2_wr_req = 1'b1; c2_AR = 16'h0088; c2_DR = 16'h9999;
    tick();
    c2_wr_req = 1'b0;
    flags("post_cap", 0, 0, 0, 0, 0, 1);
    tick();
    flags("post_wr", 1, 0, 1, 0, 0, 0);
    wr("post_wr", 8'h88, 16'h9999);

    // rr pointer was reset to core 1
    c1_wr_req = 1'b1; c1_AR = 16'h00A0; c1_DR = 16'h0A0A;
    c2_wr_req = 1'b1; c2_AR = 16'h00A1; c2_DR = 16'h0B0B;
    tick();
    c1_wr_req = 1'b0; c2_wr_req = 1'b0;
    tick();
    flags("rr_reset_first", 1, 1, 0, 0, 0, 1);
    wr("rr_reset_first", 8'hA0, 16'h0A0A);
    tick();
    flags("rr_reset_second", 1, 0, 1, 0, 0, 0);
    wr("rr_reset_second", 8'hA1, 16'h0B0B);
    tick();
    flags("final_idle", 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
